// File: rtl/prog_moore_fsm.sv
// Runtime-programmable Moore FSM: next-state and output tables loaded via a config port.
// Optional visited-state map enabled by defining FSM_VISIT_MAP_EN.
module prog_moore_fsm #(
    parameter int unsigned STATE_W     = 3,
    parameter int unsigned IN_W        = 2,
    parameter int unsigned OUT_W       = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned RESET_STATE = 0
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              run_en,
    input  logic                                              restart,
    input  logic [IN_W-1:0]                                   in,
    input  logic                                              cfg_we,
    input  logic                                              cfg_sel,
    input  logic [STATE_W-1:0]                                cfg_state,
    input  logic [IN_W-1:0]                                   cfg_in,
    input  logic [((STATE_W > OUT_W) ? STATE_W : OUT_W)-1:0]  cfg_data,
    input  logic [STATE_W-1:0]                                rd_state,
    input  logic [IN_W-1:0]                                   rd_in,
    output logic [STATE_W-1:0]                                rd_next,
    output logic [OUT_W-1:0]                                  rd_out,
    output logic [STATE_W-1:0]                                state,
    output logic [OUT_W-1:0]                                  out,
`ifdef FSM_VISIT_MAP_EN
    input  logic                                              clr_visit,
    output logic [(2**STATE_W)-1:0]                           visited,
`endif
    output logic [CNT_W-1:0]                                  trans_cnt
);

    localparam int unsigned NUM_STATES = 2 ** STATE_W;
    localparam int unsigned NUM_IN     = 2 ** IN_W;
    localparam logic [STATE_W-1:0] RESET_ST = STATE_W'(RESET_STATE);

    logic [STATE_W-1:0] next_tbl [NUM_STATES][NUM_IN];
    logic [OUT_W-1:0]   out_tbl  [NUM_STATES];

    logic [STATE_W-1:0] state_nxt;
    logic               count_en;

    always_comb begin
        state_nxt = state;
        if (restart) begin
            state_nxt = RESET_ST;
        end else if (run_en) begin
            state_nxt = next_tbl[state][in];
        end
    end

    // Only run-driven state changes count; restart-driven returns are excluded.
    assign count_en = run_en && !restart && (state_nxt != state) && (trans_cnt != '1);

    assign out     = out_tbl[state];
    assign rd_next = next_tbl[rd_state][rd_in];
    assign rd_out  = out_tbl[rd_state];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RESET_ST;
            trans_cnt <= '0;
            for (int unsigned s = 0; s < NUM_STATES; s++) begin
                out_tbl[STATE_W'(s)] <= '0;
                for (int unsigned i = 0; i < NUM_IN; i++) begin
                    next_tbl[STATE_W'(s)][IN_W'(i)] <= STATE_W'(s);
                end
            end
        end else begin
            state <= state_nxt;
            if (count_en) begin
                trans_cnt <= trans_cnt + 1'b1;
            end
            // Table writes land after the lookup above, so a same-edge transition sees the old entry.
            if (cfg_we) begin
                if (cfg_sel) begin
                    out_tbl[cfg_state] <= cfg_data[OUT_W-1:0];
                end else begin
                    next_tbl[cfg_state][cfg_in] <= cfg_data[STATE_W-1:0];
                end
            end
        end
    end

`ifdef FSM_VISIT_MAP_EN
    logic [NUM_STATES-1:0] rst_onehot;
    logic [NUM_STATES-1:0] nxt_onehot;

    assign rst_onehot = {{(NUM_STATES-1){1'b0}}, 1'b1} << RESET_ST;
    assign nxt_onehot = {{(NUM_STATES-1){1'b0}}, 1'b1} << state_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            visited <= rst_onehot;
        end else if (clr_visit) begin
            visited <= rst_onehot | ((state_nxt != state) ? nxt_onehot : '0);
        end else begin
            visited <= visited | nxt_onehot;
        end
    end
`endif

endmodule

// File: tb/tb_prog_moore_fsm.sv
// Scoreboard bench for prog_moore_fsm: a table-based reference model predicts every cycle.
// Define FSM_VISIT_MAP_EN to also check the visited-state map.
module tb_prog_moore_fsm;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned IN_W    = 2;
    localparam int unsigned OUT_W   = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned DW      = 4;
    localparam int NS   = 8;
    localparam int NI   = 4;
    localparam int CMAX = 15;
    localparam int RST  = 0;

    logic clk = 1'b0;
    logic reset, run_en, restart, cfg_we, cfg_sel, clr_visit;
    logic [IN_W-1:0]    in_sym, cfg_in, rd_in;
    logic [STATE_W-1:0] cfg_state, rd_state;
    logic [DW-1:0]      cfg_data;
    logic [STATE_W-1:0] rd_next, state;
    logic [OUT_W-1:0]   rd_out, out_w;
    logic [CNT_W-1:0]   trans_cnt;
    logic [NS-1:0]      visited;

    always #5 clk = ~clk;

    prog_moore_fsm #(.STATE_W(STATE_W), .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .RESET_STATE(RST)) dut (
        .clk(clk), .reset(reset), .run_en(run_en), .restart(restart), .in(in_sym),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_state(cfg_state), .cfg_in(cfg_in), .cfg_data(cfg_data),
        .rd_state(rd_state), .rd_in(rd_in), .rd_next(rd_next), .rd_out(rd_out),
        .state(state), .out(out_w),
`ifdef FSM_VISIT_MAP_EN
        .clr_visit(clr_visit), .visited(visited),
`endif
        .trans_cnt(trans_cnt)
    );

`ifndef FSM_VISIT_MAP_EN
    assign visited = '0;
`endif

    typedef struct {
        int st;
        int ot;
        int cnt;
        int rdn;
        int rdo;
        int vis;
    } exp_t;

    exp_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    int m_next [NS][NI];
    int m_out  [NS];
    int m_state, m_cnt, m_vis;

    task automatic chk(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: applies the documented rules to plain arrays once per edge.
    task automatic model_edge();
        int nst;
        exp_t e;
        if (reset) begin
            for (int s = 0; s < NS; s++) begin
                m_out[s] = 0;
                for (int i = 0; i < NI; i++) m_next[s][i] = s;
            end
            m_state = RST;
            m_cnt   = 0;
            m_vis   = 1 << RST;
        end else begin
            if (restart)     nst = RST;
            else if (run_en) nst = m_next[m_state][in_sym];
            else             nst = m_state;
            if (!restart && run_en && nst != m_state && m_cnt < CMAX) m_cnt = m_cnt + 1;
            if (clr_visit) m_vis = (1 << RST) | ((nst != m_state) ? (1 << nst) : 0);
            else           m_vis = m_vis | (1 << nst);
            if (cfg_we) begin
                if (cfg_sel) m_out[cfg_state] = int'(cfg_data) % 16;
                else         m_next[cfg_state][cfg_in] = int'(cfg_data) % 8;
            end
            m_state = nst;
        end
        e.st  = m_state;
        e.ot  = m_out[m_state];
        e.cnt = m_cnt;
        e.rdn = m_next[rd_state][rd_in];
        e.rdo = m_out[rd_state];
        e.vis = m_vis;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("state",     int'(state),     e.st);
            chk("out",       int'(out_w),     e.ot);
            chk("trans_cnt", int'(trans_cnt), e.cnt);
            chk("rd_next",   int'(rd_next),   e.rdn);
            chk("rd_out",    int'(rd_out),    e.rdo);
`ifdef FSM_VISIT_MAP_EN
            chk("visited",   int'(visited),   e.vis);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
        reset = 1'b0; restart = 1'b0; cfg_we = 1'b0; clr_visit = 1'b0;
    endtask

    task automatic wr(input logic sel, input int s, input int i, input int d);
        cfg_we = 1'b1; cfg_sel = sel;
        cfg_state = STATE_W'(s); cfg_in = IN_W'(i); cfg_data = DW'(d);
        cyc();
    endtask

    task automatic load_ring();
        run_en = 1'b0;
        for (int s = 0; s < NS; s++) wr(1'b0, s, 1, (s + 1) % NS);
        for (int s = 0; s < NS; s++) wr(1'b1, s, 0, s + 8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; run_en = 1'b0; restart = 1'b0; in_sym = '0;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_state = '0; cfg_in = '0; cfg_data = '0;
        rd_state = '0; rd_in = '0; clr_visit = 1'b0;
        cyc();
        reset = 1'b1; cyc();

        // Default self-loops: nothing moves.
        run_en = 1'b1;
        for (int k = 0; k < 8; k++) begin in_sym = IN_W'(k); cyc(); end

        load_ring();
        rd_state = 3'd3; rd_in = 2'd1;
        run_en = 1'b1; in_sym = 2'd1;
        for (int k = 0; k < 10; k++) cyc();
        run_en = 1'b0;
        for (int k = 0; k < 3; k++) cyc();
        run_en = 1'b1; cyc();

        // state is 3: write next_tbl[3][1]=6 on the transition edge.
        wr(1'b0, 3, 1, 6);
        run_en = 1'b0; cyc();
        wr(1'b0, 3, 1, 4);

        run_en = 1'b1;
        for (int k = 0; k < 20; k++) cyc();
        run_en = 1'b0; restart = 1'b1; cyc();
        run_en = 1'b1; restart = 1'b1; cyc();
        reset = 1'b1; cfg_we = 1'b1; cfg_sel = 1'b1; cfg_state = '0; cfg_data = 4'hF; cyc();
        run_en = 1'b0; cyc();

        // Visited-map scenario (model tracks it; DUT checked only when the map exists).
        reset = 1'b1; cyc();
        load_ring();
        run_en = 1'b1; in_sym = 2'd1;
        for (int k = 0; k < 4; k++) cyc();
        clr_visit = 1'b1; cyc();
        cyc();

        for (int k = 0; k < 300; k++) begin
            reset     = ($urandom_range(49) == 0);
            restart   = ($urandom_range(19) == 0);
            run_en    = ($urandom_range(3) != 0);
            in_sym    = IN_W'($urandom_range(NI - 1));
            cfg_we    = ($urandom_range(2) == 0);
            cfg_sel   = 1'($urandom_range(1));
            cfg_state = STATE_W'($urandom_range(NS - 1));
            cfg_in    = IN_W'($urandom_range(NI - 1));
            cfg_data  = DW'($urandom_range(15));
            rd_state  = STATE_W'($urandom_range(NS - 1));
            rd_in     = IN_W'($urandom_range(NI - 1));
            clr_visit = ($urandom_range(15) == 0);
            cyc();
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prog_moore_fsm.md
Name: prog_moore_fsm

Overview:
- Runtime-programmable Moore state machine.
- Next-state and output tables are loaded through a config write port rather than driven per cycle.
- Generalised in state count, input width and output width; adds a run gate, table readback and a saturating transition counter.
- Serves as the reusable FSM core for protocol/sequence experiments; tables are loaded by a host or the testbench.

Parameters:
- STATE_W, 3, state register width; NUM_STATES = 2**STATE_W
- IN_W, 2, input symbol width; NUM_IN = 2**IN_W
- OUT_W, 4, Moore output width
- CNT_W, 16, transition counter width
- RESET_STATE, 0, state entered on reset and on soft restart

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- run_en  input  1  1 = take transitions; 0 = hold state
- restart  input  1  soft return to RESET_STATE; tables kept
- in  input  IN_W  input symbol sampled each run cycle
- cfg_we  input  1  table write strobe
- cfg_sel  input  1  0 = next-state table, 1 = output table
- cfg_state  input  STATE_W  table row (source state)
- cfg_in  input  IN_W  table column (input symbol); ignored when cfg_sel=1
- cfg_data  input  max(STATE_W,OUT_W)  write data; low STATE_W or OUT_W bits used
- rd_state  input  STATE_W  readback row
- rd_in  input  IN_W  readback column
- rd_next  output  STATE_W  next_tbl[rd_state][rd_in], combinational
- rd_out  output  OUT_W  out_tbl[rd_state], combinational
- state  output  STATE_W  current state register
- out  output  OUT_W  Moore output = out_tbl[state]
- trans_cnt  output  CNT_W  count of state changes, saturating

Behaviour:
- Reset (reset=1 at clk edge):
  - state = RESET_STATE; trans_cnt = 0.
  - next_tbl[s][i] = s for all s, i (every entry self-loops).
  - out_tbl[s] = 0, so out = 0 the cycle after reset.
- Next-state rule on each edge with reset=0, in priority order:
  - restart=1: state <= RESET_STATE; trans_cnt unchanged; restart has priority over run_en.
  - else run_en=1: state <= next_tbl[state][in], using table contents before any same-edge write.
  - else: state holds.
- Transition counter:
  - Increments by 1 on a run_en transition only when the new state differs from the current state.
  - Self-loops and restart do not count.
  - Saturates at 2**CNT_W-1; never wraps.
- Output:
  - out is combinational from the registered state and out_tbl; no combinational path from in.
  - Latency: a change on in is visible on state and out 1 cycle later.
- Config write (cfg_we=1):
  - cfg_sel=0: next_tbl[cfg_state][cfg_in] <= cfg_data[STATE_W-1:0].
  - cfg_sel=1: out_tbl[cfg_state] <= cfg_data[OUT_W-1:0].
  - Writes take effect for lookups in the following cycle.
  - A write and a transition on the same edge: the transition uses the old entry.
  - A write to out_tbl[state] changes out the next cycle, even with run_en=0.
- Reset mid-run or mid-config: reset wins over every other input; any write on that edge is discarded.
- All table indices are full-range, so there are no illegal states or illegal writes.
- Readback ports reflect writes from the previous edge onward.

Optional Feature:
- Macro: FSM_VISIT_MAP_EN.
- With the macro defined:
  - Adds output port visited (width NUM_STATES) and input port clr_visit (width 1).
  - visited[s] is set the cycle state becomes s, and remains set until cleared.
  - reset or clr_visit clears visited to one-hot(RESET_STATE).
  - clr_visit on the same edge as a transition: the result is one-hot of the new state OR'd with one-hot(RESET_STATE).
- Without the macro: the visited and clr_visit ports are absent and no map logic is built.

Test Plan:
- Reset, then run_en=1 with in cycling 0..3 for 8 cycles -> state stays 0, out=0, trans_cnt=0 (default self-loops).
- Load a ring table (next_tbl[s][1] = s+1 mod 8, out_tbl[s] = s+8), hold in=1, run 10 cycles:
  - state sequence 1,2,...,7,0,1,2.
  - out = state+8 each cycle.
  - trans_cnt = 10.
- With the ring table loaded, toggle run_en=0 for 3 cycles -> state and out frozen, trans_cnt frozen; resumes from the same state.
- With state=3, in=1, write next_tbl[3][1]=6 on the same edge as run_en=1 -> state becomes 4 (old entry); readback rd_next for rd_state=3, rd_in=1 returns 6 next cycle.
- Set CNT_W=4, run the ring for 20 cycles -> trans_cnt stops at 15. Then assert restart -> state=0, trans_cnt still 15. Then assert reset -> all tables cleared, out=0.
- With FSM_VISIT_MAP_EN defined, run the ring from 0 to 4 -> visited=8'h1F. Assert clr_visit while transitioning 4->5 -> visited=8'h21.
